spi_fifo_ctrl: RTL
==================

Name: spi_fifo_ctrl

Overview:
Byte-stream sequencer that sits directly upstream of the SPI master byte engine. It holds a TX FIFO and an RX FIFO, drives the master's start/data/read inputs, and keeps start asserted at each byte boundary so a multi-byte burst goes out back-to-back under a single SS assertion. Received bytes are captured into the RX FIFO. The bus-side register block sees only FIFO ports, a go/busy/done handshake and sticky error flags.

Parameters:
DEPTH, 8, entries per FIFO; power of two, 2..64.
CW, $clog2(DEPTH)+1, width of the count outputs (derived; do not override).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
tx_we_i  in  1  push tx_wdata_i into TX FIFO
tx_wdata_i  in  8  TX byte
tx_full_o  out  1  TX FIFO full
tx_cnt_o  out  CW  TX occupancy
rx_re_i  in  1  pop RX FIFO head
rx_rdata_o  out  8  RX FIFO head; valid when rx_empty_o=0
rx_empty_o  out  1  RX FIFO empty
rx_cnt_o  out  CW  RX occupancy
go_i  in  1  start burst; honoured only when busy_o=0
read_i  in  1  burst type latched at go: 0 = write, 1 = read
len_i  in  16  burst length in bytes, latched at go
clear_i  in  1  flush both FIFOs and clear error flags; honoured only when busy_o=0
busy_o  out  1  burst in progress
done_o  out  1  1-cycle pulse at burst end
tx_ovf_o  out  1  sticky: push attempted while TX FIFO full
rx_ovf_o  out  1  sticky: RX byte dropped because RX FIFO full
m_start_o  out  1  to master start_i
m_read_o  out  1  to master read_i; equals the latched read_i
m_data_o  out  8  to master data_i
m_ready_i  in  1  from master ready_o (1 = master idle)
m_data_valid_i  in  1  from master data_valid_o; 1-cycle pulse per finished byte
m_data_i  in  8  from master data_o

Behaviour:
- Reset values: all outputs 0, except rx_empty_o=1 and m_data_o=8'hFF. Both FIFOs empty, state IDLE, remaining counter 0, error flags 0.
- FIFOs:
  - Synchronous, first-word-fall-through.
  - Push when full is dropped; for TX, this also sets tx_ovf_o.
  - Pop when empty is ignored.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - A push on a full FIFO is rejected even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- States: IDLE, ISSUE, RUN, DRAIN, DONE.
- IDLE:
  - busy_o=0; m_start_o=0.
  - go_i with len_i=0: go to DONE, no SPI activity.
  - go_i with len_i>0: latch read_i and len_i into mode and rem, then go to ISSUE.
  - clear_i in IDLE flushes both FIFOs and clears both error flags.
  - clear_i is ignored outside IDLE.
  - go_i and clear_i in the same cycle: clear takes effect, then go is taken.
- can_issue: (mode=1 OR TX non-empty) AND RX not full.
- ISSUE:
  - Wait for m_ready_i=1 and can_issue.
  - Then assert m_start_o for exactly 1 cycle with m_data_o = TX head (write) or 8'hFF (read); pop TX in write mode; go to RUN.
- RUN:
  - Wait for m_data_valid_i.
  - In that cycle: push m_data_i into the RX FIFO if mode=1; if the RX FIFO is full, drop the byte and set rx_ovf_o.
  - Decrement rem.
  - If rem-1 > 0 and can_issue (RX "not full" evaluated after this cycle's push, ignoring any same-cycle rx_re_i): assert m_start_o combinationally in the same cycle, drive m_data_o, pop TX if write mode, stay in RUN. This is the back-to-back case: SS stays asserted and the master continues immediately.
  - Else if rem-1 > 0: m_start_o=0 (the master ends the frame and releases SS); go to ISSUE. This is the underrun stall.
  - Else (rem-1 = 0): go to DRAIN.
- DRAIN: wait for m_ready_i=1 (SS released, master idle), then go to DONE.
- DONE: done_o=1 for 1 cycle; busy_o drops to 0 in the same cycle; go to IDLE.
- busy_o=1 in ISSUE, RUN and DRAIN.
- m_start_o is never asserted outside ISSUE and RUN.
- m_data_o holds 8'hFF whenever m_start_o=0.
- TX bytes pushed during a burst are consumed by that burst.
- Leftover TX bytes after the burst remain queued.
- In write mode, received bytes are discarded.
- rst_ni asserted mid-burst: immediate return to reset values. The master is on the same reset, so no orphaned transfer remains.

Test Plan:
1. Push A5,5A,C3; go write len=3; master model returns valid after 20 cycles per byte -> m_start_o pulses 3 times with data A5,5A,C3; the 2nd and 3rd pulses coincide with m_data_valid_i; done_o after m_ready_i; TX empty; RX empty.
2. go read len=4; slave returns 11,22,33,44 -> m_data_o=FF on every start; RX holds 11,22,33,44 in order; rx_cnt_o=4; done_o pulses once.
3. Push 1 byte; go write len=2; push the 2nd byte 50 cycles after the first valid -> m_start_o=0 at the first valid; controller waits in ISSUE until m_ready_i=1 and the byte arrives, then issues; done_o fires after the 2nd byte.
4. DEPTH=8, read len=10, no RX pops -> 8 bytes accepted; issue stalls on RX full; popping 2 bytes releases the stall; all 10 bytes delivered; rx_ovf_o stays 0. Separately, forcing a full RX at a valid -> byte dropped and rx_ovf_o=1.
5. 9 pushes into an empty TX FIFO -> tx_cnt_o=8; tx_ovf_o=1; clear_i while idle -> counts 0, flags 0; clear_i while busy -> ignored.
6. go len=0 -> done_o exactly 1 cycle later, no m_start_o. Reset mid-RUN -> all outputs at reset values next cycle; FIFOs empty.

Source files
------------

// File: rtl/spi_fifo_ctrl_if.sv
// Link between the FIFO sequencer and the SPI master byte engine.
// The sequencer drives the master, so it takes the master modport.
interface spi_fifo_ctrl_if;
    logic       m_start_o;
    logic       m_read_o;
    logic [7:0] m_data_o;
    logic       m_ready_i;
    logic       m_data_valid_i;
    logic [7:0] m_data_i;

    modport master (
        output m_start_o, m_read_o, m_data_o,
        input  m_ready_i, m_data_valid_i, m_data_i
    );
    modport slave (
        input  m_start_o, m_read_o, m_data_o,
        output m_ready_i, m_data_valid_i, m_data_i
    );
endinterface

// File: rtl/spi_fifo_ctrl.sv
// TX/RX byte FIFOs plus a burst sequencer that keeps the SPI master fed
// back-to-back so a multi-byte burst stays under one SS assertion.
module spi_fifo_ctrl_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic [CW-1:0] cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          push_ok, pop_ok;

    // Full-check uses the pre-pop count, so a push on full is dropped even with a pop.
    assign push_ok = push_i & (cnt_q != CW'(DEPTH));
    assign pop_ok  = pop_i & (cnt_q != '0);
    assign rdata_o = mem_q[rptr_q];
    assign cnt_o   = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
endmodule

module spi_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          tx_we_i,
    input  logic [7:0]    tx_wdata_i,
    output logic          tx_full_o,
    output logic [CW-1:0] tx_cnt_o,
    input  logic          rx_re_i,
    output logic [7:0]    rx_rdata_o,
    output logic          rx_empty_o,
    output logic [CW-1:0] rx_cnt_o,
    input  logic          go_i,
    input  logic          read_i,
    input  logic [15:0]   len_i,
    input  logic          clear_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          tx_ovf_o,
    output logic          rx_ovf_o,
    spi_fifo_ctrl_if.master m
);
    typedef enum logic [2:0] {IDLE, ISSUE, RUN, DRAIN, DONE} state_e;

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [15:0]   rem_q, rem_d;
    logic          tx_ovf_q, rx_ovf_q;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [7:0]    tx_head, rx_head;
    logic          tx_empty, tx_full, rx_full;
    logic          flush, start, tx_pop, rx_push, rx_ovf_set;
    logic          can_issue, rx_full_post, can_issue_post;

    spi_fifo_ctrl_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx (
        .clk_i, .rst_ni, .flush_i(flush), .push_i(tx_we_i), .wdata_i(tx_wdata_i),
        .pop_i(tx_pop), .rdata_o(tx_head), .cnt_o(tx_cnt)
    );
    spi_fifo_ctrl_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx (
        .clk_i, .rst_ni, .flush_i(flush), .push_i(rx_push), .wdata_i(m.m_data_i),
        .pop_i(rx_re_i), .rdata_o(rx_head), .cnt_o(rx_cnt)
    );

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == CW'(DEPTH));
    assign rx_full  = (rx_cnt == CW'(DEPTH));

    assign can_issue      = (mode_q | ~tx_empty) & ~rx_full;
    // Fullness after this cycle's RX push; a same-cycle pop is deliberately not credited.
    assign rx_full_post   = rx_full | (mode_q & (rx_cnt == CW'(DEPTH - 1)));
    assign can_issue_post = (mode_q | ~tx_empty) & ~rx_full_post;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        rem_d      = rem_q;
        start      = 1'b0;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        rx_ovf_set = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            IDLE: begin
                flush = clear_i;
                if (go_i) begin
                    if (len_i == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        mode_d  = read_i;
                        rem_d   = len_i;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (m.m_ready_i && can_issue) begin
                    start   = 1'b1;
                    tx_pop  = ~mode_q;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (m.m_data_valid_i) begin
                    rx_push    = mode_q & ~rx_full;
                    rx_ovf_set = mode_q & rx_full;
                    rem_d      = rem_q - 16'd1;
                    if (rem_q > 16'd1) begin
                        // Restart on the valid cycle itself so SS never drops mid-burst.
                        if (can_issue_post) begin
                            start  = 1'b1;
                            tx_pop = ~mode_q;
                        end else begin
                            state_d = ISSUE;
                        end
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: if (m.m_ready_i) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            rem_q    <= '0;
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            if (flush)                    tx_ovf_q <= 1'b0;
            else if (tx_we_i && tx_full)  tx_ovf_q <= 1'b1;
            if (flush)                    rx_ovf_q <= 1'b0;
            else if (rx_ovf_set)          rx_ovf_q <= 1'b1;
        end
    end

    assign tx_full_o  = tx_full;
    assign tx_cnt_o   = tx_cnt;
    assign rx_cnt_o   = rx_cnt;
    assign rx_empty_o = (rx_cnt == '0);
    assign rx_rdata_o = (rx_cnt == '0) ? 8'h00 : rx_head;
    assign busy_o     = (state_q == ISSUE) || (state_q == RUN) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);
    assign tx_ovf_o   = tx_ovf_q;
    assign rx_ovf_o   = rx_ovf_q;
    assign m.m_start_o = start;
    assign m.m_read_o  = mode_q;
    assign m.m_data_o  = (start && !mode_q) ? tx_head : 8'hFF;
endmodule
